// File: rtl/slow_mem_responder.sv
// Fixed-latency 128-bit line memory responder for the I/D cache refill port.
// Counts completed reads and writes and flags simultaneous read/write requests.
module slow_mem_responder #(
    parameter int LATENCY    = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [27:0]      mem_addr,
    input  logic [127:0]     mem_wdata,
    output logic [127:0]     mem_rdata,
    output logic             mem_ready,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count,
    output logic             proto_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [127:0]          r_wdata;
    logic                  r_wr;
    logic [127:0]          r_mem [0:(1<<DEPTH_LOG2)-1];

    logic                  w_req;
    logic                  w_accept;
    logic                  w_enter;
    logic                  w_commit;
    logic                  w_load_rd;
    logic                  w_op_wr;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [127:0]          w_wdata;
    logic                  w_unused_addr;

    assign w_req         = mem_read | mem_write;
    assign w_accept      = (r_state == IDLE) && w_req;
    assign w_unused_addr = ^mem_addr[27:DEPTH_LOG2];

    // With LATENCY=1 the response is formed on the accept edge itself,
    // so the live inputs stand in for the not-yet-latched request.
    assign w_op_wr = (r_state == IDLE) ? mem_write : r_wr;
    assign w_idx   = (r_state == IDLE) ? mem_addr[DEPTH_LOG2-1:0] : r_idx;
    assign w_wdata = (r_state == IDLE) ? mem_wdata : r_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == 8'd1) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_enter   = (w_next == RESP) && (r_state != RESP);
        w_commit  = w_enter && w_op_wr;
        w_load_rd = w_enter && !w_op_wr;
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_commit) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_wr      <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            proto_err <= 1'b0;
        end else begin
            mem_ready <= w_enter;
            if (w_accept) begin
                r_cnt   <= 8'(LATENCY - 1);
                r_idx   <= mem_addr[DEPTH_LOG2-1:0];
                r_wdata <= mem_wdata;
                r_wr    <= mem_write;
                if (mem_read && mem_write) begin
                    proto_err <= 1'b1;
                end
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_load_rd) begin
                mem_rdata <= r_mem[w_idx];
            end
            if (r_state == RESP) begin
                if (r_wr) begin
                    if (wr_count != '1) wr_count <= wr_count + 1'b1;
                end else begin
                    if (rd_count != '1) rd_count <= rd_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_slow_mem_responder.sv
// Directed bench: LATENCY=8 instance driven from a vector table,
// LATENCY=1 instance and reset-abort covered by hand sequences.
module tb_slow_mem_responder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         a_rd = 1'b0, a_wr = 1'b0;
    logic [27:0]  a_addr = '0;
    logic [127:0] a_wdata = '0, a_rdata;
    logic         a_ready, a_pe;
    logic [15:0]  a_rdc, a_wrc;

    logic         b_rd = 1'b0, b_wr = 1'b0;
    logic [27:0]  b_addr = '0;
    logic [127:0] b_wdata = '0, b_rdata;
    logic         b_ready, b_pe;
    logic [15:0]  b_rdc, b_wrc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    slow_mem_responder #(.LATENCY(8), .DEPTH_LOG2(8), .CNT_W(16)) u8 (
        .clk(clk), .rst_n(rst_n), .mem_read(a_rd), .mem_write(a_wr),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata),
        .mem_ready(a_ready), .rd_count(a_rdc), .wr_count(a_wrc),
        .proto_err(a_pe));

    slow_mem_responder #(.LATENCY(1), .DEPTH_LOG2(8), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .mem_read(b_rd), .mem_write(b_wr),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
        .mem_ready(b_ready), .rd_count(b_rdc), .wr_count(b_wrc),
        .proto_err(b_pe));

    typedef struct {
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_rdata;
        logic [15:0]  exp_rdc;
        logic [15:0]  exp_wrc;
        logic         exp_pe;
    } vec_t;

    vec_t vt[7];

    localparam logic [127:0] D1 = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
    localparam logic [127:0] D2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] D3 = 128'h33333333_44444444_55555555_66666666;
    localparam logic [127:0] DA = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
    localparam logic [127:0] DB = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One transaction on the LATENCY=8 instance; returns edges from
    // accept to the first ready sample and the ready value one cycle later.
    task automatic txn8(input logic rd, input logic wr,
                        input logic [27:0] addr, input logic [127:0] wd,
                        output int lat, output logic after);
        a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wd;
        @(posedge clk); #1;
        lat = 0;
        while (!a_ready && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        a_rd = 1'b0; a_wr = 1'b0;
        @(posedge clk); #1;
        after = a_ready;
    endtask

    initial begin
        int   lat;
        logic after;
        logic seen;
        vt[0] = '{1'b0, 1'b1, 28'h0000010, D1, '0, 16'd0, 16'd1, 1'b0};
        vt[1] = '{1'b1, 1'b0, 28'h0000010, '0, D1, 16'd1, 16'd1, 1'b0};
        vt[2] = '{1'b0, 1'b1, 28'h0000105, D2, D1, 16'd1, 16'd2, 1'b0};
        vt[3] = '{1'b1, 1'b0, 28'h0000005, '0, D2, 16'd2, 16'd2, 1'b0};
        vt[4] = '{1'b1, 1'b1, 28'h0000003, D3, D2, 16'd2, 16'd3, 1'b1};
        vt[5] = '{1'b1, 1'b0, 28'h0000003, '0, D3, 16'd3, 16'd3, 1'b1};
        vt[6] = '{1'b1, 1'b0, 28'h0000010, '0, D1, 16'd4, 16'd3, 1'b1};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("rst_outputs_l8",
                {a_ready, a_pe, a_rdc, a_wrc, a_rdata[31:0]}, '0);
            chk("rst_outputs_l1",
                {b_ready, b_pe, b_rdc, b_wrc, b_rdata[31:0]}, '0);
        end

        for (int i = 0; i < 7; i++) begin
            txn8(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, lat, after);
            chk($sformatf("v%0d_latency", i), 128'(lat), 128'd7);
            chk($sformatf("v%0d_pulse_width", i), 128'(after), 128'd0);
            chk($sformatf("v%0d_rdata", i), a_rdata, vt[i].exp_rdata);
            chk($sformatf("v%0d_rd_count", i), 128'(a_rdc), 128'(vt[i].exp_rdc));
            chk($sformatf("v%0d_wr_count", i), 128'(a_wrc), 128'(vt[i].exp_wrc));
            chk($sformatf("v%0d_proto_err", i), 128'(a_pe), 128'(vt[i].exp_pe));
        end

        // LATENCY=1: request held through the RESP-exit edge is not re-accepted
        for (int r = 0; r < 2; r++) begin
            b_rd = 1'b1; b_addr = 28'(r + 1);
            @(posedge clk); #1;
            chk($sformatf("l1_r%0d_ready", r), 128'(b_ready), 128'd1);
            @(posedge clk); #1;
            chk($sformatf("l1_r%0d_drop", r), 128'(b_ready), 128'd0);
            b_rd = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("l1_r%0d_no_dup", r), 128'(b_ready), 128'd0);
        end
        chk("l1_rd_count", 128'(b_rdc), 128'd2);
        chk("l1_wr_count", 128'(b_wrc), 128'd0);

        // Reset during BUSY abandons a write
        txn8(1'b0, 1'b1, 28'h0000020, DA, lat, after);
        chk("pre_write_latency", 128'(lat), 128'd7);
        a_wr = 1'b1; a_addr = 28'h0000020; a_wdata = DB;
        @(posedge clk); #1;
        a_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_counts", {a_rdc, a_wrc, a_pe, a_ready}, '0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            seen |= a_ready;
        end
        chk("abort_no_ready", 128'(seen), 128'd0);
        txn8(1'b1, 1'b0, 28'h0000020, '0, lat, after);
        chk("abort_read_latency", 128'(lat), 128'd7);
        chk("abort_read_data", a_rdata, DA);
        chk("abort_rd_count", 128'(a_rdc), 128'd1);
        chk("abort_wr_count", 128'(a_wrc), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/slow_mem_responder.md
Name: slow_mem_responder

Overview:
- Responder end of the 128-bit line-transfer protocol that the I and D caches drive (mem_read/mem_write/mem_addr[31:4]/mem_wdata/mem_rdata/mem_ready).
- Synthesizable, parameterized-latency memory model: one per cache port in system-level simulation and on the FPGA prototype.
- Holds 2^DEPTH_LOG2 lines of 128 bits.
- Keeps read/write transaction counters for cache miss-rate measurement.

Parameters:
- LATENCY, 8: cycles from request-accept edge to the cycle mem_ready is high; legal range 1..255.
- DEPTH_LOG2, 8: log2 of line count; line index = mem_addr[DEPTH_LOG2+3:4].
- CNT_W, 16: width of transaction counters.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- mem_read  input  1  line read request, held by initiator until mem_ready seen
- mem_write  input  1  line write request, held by initiator until mem_ready seen
- mem_addr  input  28  line address, bits [31:4]
- mem_wdata  input  128  write line data
- mem_rdata  output  128  read line data, valid only while mem_ready=1
- mem_ready  output  1  one-cycle completion pulse
- rd_count  output  CNT_W  completed reads, saturating
- wr_count  output  CNT_W  completed writes, saturating
- proto_err  output  1  sticky: mem_read and mem_write both high at accept

Behaviour:
- Interface decision: single clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge): state<=IDLE, mem_ready<=0, mem_rdata<=0, rd_count<=0, wr_count<=0, proto_err<=0, latency counter<=0.
- Reset does not clear line storage; contents are undefined until written or preloaded.
- All outputs are registered.
- States: IDLE, BUSY, RESP.
- IDLE: at an edge with mem_read|mem_write=1, latch addr, wdata and op, and load cnt=LATENCY-1.
  - If LATENCY=1, go straight to RESP; otherwise go to BUSY.
  - Both requests high at accept: treat as write and set proto_err.
- BUSY: decrement cnt each edge. At the edge where cnt==1, go to RESP and assert mem_ready for the next cycle.
  - Request inputs are ignored while BUSY; the latched values are used.
  - Dropping the request during BUSY does not abort the transaction.
- RESP (mem_ready=1 for exactly one cycle):
  - Read: mem_rdata = line[latched index], value taken at the RESP-entry edge.
  - Write: line[latched index] <= latched wdata at the RESP-entry edge; mem_rdata holds its previous value.
  - Next edge: mem_ready<=0, counter for the completed op +1 (saturate at all-ones), state<=IDLE.
- Timing: request first sampled at edge k gives mem_ready high during the cycle after edge k+LATENCY-1, i.e. exactly LATENCY cycles after accept.
- Back-to-back: the initiator must drop its request at the edge where it samples mem_ready=1.
  - A request present at the edge leaving RESP is not accepted there; it is accepted at the following edge in IDLE. Minimum request-to-request spacing is LATENCY+1 cycles.
- Read after write to the same line returns the written data.
- Address bits above DEPTH_LOG2+3 are ignored; addresses alias.
- Reset asserted during BUSY or RESP: transaction abandoned, a pending write is not committed, counters cleared.

Test Plan:
- Reset hold 2 cycles, then idle 5 cycles -> mem_ready=0, mem_rdata=0, rd_count=0, wr_count=0, proto_err=0 throughout.
- LATENCY=8: write addr 28'h0000010, data 128'hDEADBEEF_00000001_CAFEF00D_12345678, then read same addr -> each mem_ready pulse is 1 cycle wide, 8 cycles after accept; read returns the written data; wr_count=1, rd_count=1.
- LATENCY=1: reads to 28'h1 and 28'h2, each issued 2 cycles apart -> mem_ready in the cycle after each accept; no duplicate accept; rd_count=2.
- Aliasing with DEPTH_LOG2=8: write 28'h0000105, read 28'h0000005 -> same data returned.
- mem_read and mem_write both high with addr 28'h3 -> treated as write, proto_err=1 and stays 1; wr_count increments.
- Write issued, rst_n low for 1 cycle during BUSY, then read same addr -> the aborted write is not committed (old preloaded value returned); counters restart from 0.
